// File: rtl/any1_ibuf.sv
// Instruction queue between the aligner and decode: a circular FIFO of
// instruction/IP/PIP/predict-taken entries with flush and occupancy count.
module any1_ibuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AWID  = 32,
    parameter int unsigned IRW   = 64
) (
    input  logic                     rst_i,
    input  logic                     clk_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [IRW-1:0]           in_ir_i,
    input  logic [AWID-1:0]          in_ip_i,
    input  logic [AWID-1:0]          in_pip_i,
    input  logic                     in_pt_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [IRW-1:0]           out_ir_o,
    output logic [AWID-1:0]          out_ip_o,
    output logic [AWID-1:0]          out_pip_o,
    output logic                     out_pt_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [IRW-1:0]  ir;
        logic [AWID-1:0] ip;
        logic [AWID-1:0] pip;
        logic            pt;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         head;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push;
    logic           pop;

    // Handshakes depend only on registered occupancy, so a full queue refuses
    // a push even while decode is draining it in the same cycle.
    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            mem_q[wptr_q] <= '{ir: in_ir_i, ip: in_ip_i, pip: in_pip_i, pt: in_pt_i};
        end
    end

    // Storage is never cleared; an empty queue presents zeros by masking.
    always_comb begin
        head      = mem_q[rptr_q];
        out_ir_o  = '0;
        out_ip_o  = '0;
        out_pip_o = '0;
        out_pt_o  = 1'b0;
        if (out_valid_o) begin
            out_ir_o  = head.ir;
            out_ip_o  = head.ip;
            out_pip_o = head.pip;
            out_pt_o  = head.pt;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_any1_ibuf.sv
// Directed self-checking bench for any1_ibuf at the default DEPTH=4 configuration.
module tb_any1_ibuf;

    logic        rst_i = 1'b1;
    logic        clk_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] in_ir_i = '0;
    logic [31:0] in_ip_i = '0;
    logic [31:0] in_pip_i = '0;
    logic        in_pt_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [63:0] out_ir_o;
    logic [31:0] out_ip_o;
    logic [31:0] out_pip_o;
    logic        out_pt_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    any1_ibuf #(.DEPTH(4), .AWID(32), .IRW(64)) dut (
        .rst_i       (rst_i),
        .clk_i       (clk_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ir_i     (in_ir_i),
        .in_ip_i     (in_ip_i),
        .in_pip_i    (in_pip_i),
        .in_pt_i     (in_pt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ir_o    (out_ir_o),
        .out_ip_o    (out_ip_o),
        .out_pip_o   (out_pip_o),
        .out_pt_o    (out_pt_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] ir, input logic [31:0] ip,
                         input logic [31:0] pip, input logic pt);
        in_valid_i = v;
        in_ir_i    = ir;
        in_ip_i    = ip;
        in_pip_i   = pip;
        in_pt_i    = pt;
    endtask

    initial begin
        logic [63:0] exp_ir [4];
        exp_ir[0] = 64'h21; exp_ir[1] = 64'h22; exp_ir[2] = 64'h23; exp_ir[3] = 64'h24;

        // Reset
        step(); step();
        rst_i = 1'b0;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_ir", out_ir_o, 64'd0);
        check("rst_ip", 64'(out_ip_o), 64'd0);

        // Single push into empty queue, no same-cycle bypass
        drive(1'b1, 64'h11, 32'h100, 32'hFC, 1'b0);
        #1;
        check("nobypass_valid", 64'(out_valid_o), 64'd0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        check("p1_valid", 64'(out_valid_o), 64'd1);
        check("p1_ir", out_ir_o, 64'h11);
        check("p1_ip", 64'(out_ip_o), 64'h100);
        check("p1_count", 64'(count_o), 64'd1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("p1_pop_count", 64'(count_o), 64'd0);
        check("empty_ir_zero", out_ir_o, 64'd0);

        // Fill to full, hold a fifth, pop once, fifth accepted
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(32'h20 + i), 32'h200 + 32'(4 * i), 32'h1FC + 32'(4 * i), 1'b0);
            step();
        end
        check("full_ready", 64'(in_ready_o), 64'd0);
        check("full_count", 64'(count_o), 64'd4);
        drive(1'b1, 64'h24, 32'h210, 32'h20C, 1'b1);
        step();
        check("held_count", 64'(count_o), 64'd4);
        check("held_head", out_ir_o, 64'h20);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("full_poppush_count", 64'(count_o), 64'd3);
        check("full_poppush_head", out_ir_o, 64'h21);
        check("full_poppush_ready", 64'(in_ready_o), 64'd1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        check("fifth_in_count", 64'(count_o), 64'd4);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_ir%0d", i), out_ir_o, exp_ir[i]);
            step();
        end
        out_ready_i = 1'b0;
        check("drain_count", 64'(count_o), 64'd0);

        // Simultaneous push and pop at count 2
        drive(1'b1, 64'h31, 32'h300, 32'h2FC, 1'b0); step();
        drive(1'b1, 64'h32, 32'h304, 32'h300, 1'b0); step();
        check("two_count", 64'(count_o), 64'd2);
        drive(1'b1, 64'h33, 32'h308, 32'h304, 1'b0);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("pp_count", 64'(count_o), 64'd2);
        check("pp_head", out_ir_o, 64'h32);

        // Flush at count 3 with a push presented
        drive(1'b1, 64'h34, 32'h30C, 32'h308, 1'b0); step();
        check("three_count", 64'(count_o), 64'd3);
        drive(1'b1, 64'h99, 32'h999, 32'h995, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_ready", 64'(in_ready_o), 64'd1);
        step();
        check("flush_discard", 64'(count_o), 64'd0);
        check("flush_ir", out_ir_o, 64'd0);

        // Full throughput across pointer wrap
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h1000 + 64'(i), 32'h100 + 32'(4 * i), 32'hFC + 32'(4 * i), i[0]);
            step();
            check($sformatf("tp_ip%0d", i), 64'(out_ip_o), 64'(32'h100 + 32'(4 * i)));
            check($sformatf("tp_pip%0d", i), 64'(out_pip_o), 64'(32'hFC + 32'(4 * i)));
            check($sformatf("tp_pt%0d", i), 64'(out_pt_o), 64'(i[0]));
            check($sformatf("tp_ir%0d", i), out_ir_o, 64'h1000 + 64'(i));
            check($sformatf("tp_cnt%0d", i), 64'(count_o), 64'd1);
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        out_ready_i = 1'b0;
        check("tp_end_count", 64'(count_o), 64'd0);

        // Reset mid-stream with count 2 and a push presented
        drive(1'b1, 64'h41, 32'h400, 32'h3FC, 1'b1); step();
        drive(1'b1, 64'h42, 32'h404, 32'h400, 1'b1); step();
        check("prerst_count", 64'(count_o), 64'd2);
        drive(1'b1, 64'h43, 32'h408, 32'h404, 1'b1);
        rst_i = 1'b1;
        flush_i = 1'b1;
        step();
        rst_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        check("mrst_count", 64'(count_o), 64'd0);
        check("mrst_ready", 64'(in_ready_o), 64'd1);
        check("mrst_valid", 64'(out_valid_o), 64'd0);
        check("mrst_ir", out_ir_o, 64'd0);
        check("mrst_ip", 64'(out_ip_o), 64'd0);
        check("mrst_pip", 64'(out_pip_o), 64'd0);
        check("mrst_pt", 64'(out_pt_o), 64'd0);
        step();
        check("mrst_drop", 64'(count_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/any1_ibuf.md
ANY1_IBUF -- requirements
Module: any1_ibuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; legal values 2, 4, 8.
REQ-002 SHALL have parameter AWID, default 32, instruction-pointer width.
REQ-003 SHALL have parameter IRW, default 64, instruction-register width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port flush_i, input, 1 bit: discard all queued entries (branch mispredict or exception redirect).
REQ-008 SHALL have port in_valid_i, input, 1 bit: the aligner presents an instruction.
REQ-009 SHALL have port in_ready_o, output, 1 bit: the queue can accept an instruction.
REQ-010 SHALL have port in_ir_i, input, IRW bits: aligned instruction (alignment-fault encodings pass through unchanged).
REQ-011 SHALL have ports in_ip_i and in_pip_i, input, AWID bits each: instruction pointer and previous instruction pointer.
REQ-012 SHALL have port in_pt_i, input, 1 bit: predict-taken flag.
REQ-013 SHALL have port out_valid_o, output, 1 bit: the head entry is valid for decode.
REQ-014 SHALL have port out_ready_i, input, 1 bit: decode consumes the head entry.
REQ-015 SHALL have ports out_ir_o (IRW bits), out_ip_o (AWID), out_pip_o (AWID) and out_pt_o (1 bit), all outputs: the head-entry payload.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-017 SHALL operate as a circular FIFO with read and write pointers of $clog2(DEPTH) bits each, wrapping from DEPTH-1 to 0.
REQ-018 SHALL assert in_ready_o = (count_o != DEPTH), derived only from registered state, with no combinational path from out_ready_i.
REQ-019 SHALL push when in_valid_i && in_ready_o: write the payload at the write pointer, then advance the write pointer.
REQ-020 SHALL pop when out_valid_o && out_ready_i: advance the read pointer.
REQ-021 SHALL assert out_valid_o = (count_o != 0); the payload outputs SHALL show the head entry and SHALL be all-zero when the queue is empty.
REQ-022 SHALL have a latency of 1 cycle: an entry pushed into an empty queue appears on the outputs the next cycle; there is no same-cycle bypass.
REQ-023 SHALL leave count_o unchanged when a push and a pop occur in the same cycle; otherwise count_o is +1 on a push and -1 on a pop.
REQ-024 SHALL accept no push when full, even if a pop occurs in the same cycle; the aligner's in_valid_i/payload must hold until accepted.
REQ-025 SHALL set both pointers and count_o to 0 on the next edge when flush_i=1; a push or pop in that same cycle is ignored.
REQ-026 SHALL treat flush_i as taking priority over push and pop, and rst_i as taking priority over flush_i.
REQ-027 SHALL deliver entries in push order, with the payload bit-exact to what was pushed.
REQ-028 SHALL never let count_o exceed DEPTH or go below 0 under any input sequence.

Reset
REQ-029 SHALL on rst_i=1, at the next edge, set pointers=0, count_o=0, out_valid_o=0, in_ready_o=1, and all payload outputs to 0.
REQ-030 SHALL when rst_i is asserted mid-stream drop all entries, including any push presented in the reset cycle.
REQ-031 SHALL not require reset of the storage array contents; empty-state output zeroing is by masking.

Verification
REQ-032 SHALL be verified with: push ir=0x11, ip=0x100 into an empty queue -> out_valid_o=1 next cycle, out_ir_o=0x11, out_ip_o=0x100, count_o=1.
REQ-033 SHALL be verified with: 4 pushes with out_ready_i=0 (DEPTH=4) -> in_ready_o=0, count_o=4; a 5th in_valid_i is held and not lost; 1 pop -> 5th is accepted next cycle.
REQ-034 SHALL be verified with: count_o=2 plus a simultaneous push and pop -> count_o stays 2 and the output advances to the second entry.
REQ-035 SHALL be verified with: count_o=3 plus flush_i=1 with in_valid_i=1 -> count_o=0, out_valid_o=0, and the pushed entry is discarded.
REQ-036 SHALL be verified with: 10 sequential pushes and pops at full throughput (ip 0x100..0x124 step 4) -> outputs in order across pointer wrap, pt/pip preserved.
REQ-037 SHALL be verified with: rst_i=1 with count_o=2 -> next cycle count_o=0, in_ready_o=1, payload outputs 0.
